// File: rtl/uart_frame_loader_pkg.sv
// Shared constants and FSM encoding for the UART frame loader.
package uart_frame_loader_pkg;
    localparam logic [7:0] SYNC_DEFAULT = 8'hAA;
    localparam logic [7:0] CMD_IMAGE    = 8'h01;
    localparam logic [7:0] CMD_WEIGHTS  = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN_LO,
        S_LEN_HI,
        S_PAYLOAD,
        S_CHECK
    } state_t;
endpackage

// File: rtl/uart_frame_loader_watchdog.sv
// Inter-byte gap counter: cleared by each byte or while idle, expires after LIMIT silent cycles.
module loader_watchdog #(
    parameter int LIMIT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);
    localparam int TW = $clog2(LIMIT + 1);

    logic [TW-1:0] gap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              gap <= '0;
        else if (!en || clr)     gap <= '0;
        else if (!expire)        gap <= gap + 1'b1;
    end

    // A byte in the limit cycle takes priority over expiry.
    assign expire = en && !clr && (gap == TW'(LIMIT - 1));
endmodule

// File: rtl/uart_frame_loader.sv
// Framed byte-stream loader: SYNC, CMD, LEN_LO, LEN_HI, payload, XOR checksum.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module uart_frame_loader
    import uart_frame_loader_pkg::*;
#(
    parameter int          ADDR_W       = 16,
    parameter logic [15:0] MAX_LEN      = 16'd8192,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_DEFAULT,
    parameter int          TIMEOUT_CLKS = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              inf_busy,
    output logic              busy,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              frame_done,
    output logic [7:0]        frame_cmd,
    output logic              err_chk,
    output logic              err_frame,
    output logic              err_timeout
);
    localparam int CW = ADDR_W + 1;

    state_t        state;
    logic [7:0]    cmd_q;
    logic [7:0]    len_lo;
    logic [CW-1:0] len_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [7:0]    chk;
    logic [15:0]   len_in;
    logic          expire;

    assign busy   = (state != S_IDLE);
    assign cnt_nx = cnt + 1'b1;
    assign len_in = {rx_data, len_lo};

`ifdef LOADER_TIMEOUT_EN
    loader_watchdog #(.LIMIT(TIMEOUT_CLKS)) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (busy),
        .clr    (rx_ready),
        .expire (expire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CLKS > 0);
    assign expire         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cmd_q       <= '0;
            len_lo      <= '0;
            len_q       <= '0;
            cnt         <= '0;
            chk         <= '0;
            mem_we      <= 1'b0;
            mem_sel     <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            frame_done  <= 1'b0;
            frame_cmd   <= '0;
            err_chk     <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            mem_we      <= 1'b0;
            frame_done  <= 1'b0;
            err_chk     <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
            if (rx_ready) begin
                case (state)
                    S_IDLE: if (rx_data == SYNC_BYTE) state <= S_CMD;
                    S_CMD: begin
                        cmd_q <= rx_data;
                        if (rx_data == CMD_WEIGHTS) begin
                            mem_sel <= 1'b1;
                            state   <= S_LEN_LO;
                        end else if (rx_data == CMD_IMAGE && !inf_busy) begin
                            mem_sel <= 1'b0;
                            state   <= S_LEN_LO;
                        end else begin
                            err_frame <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                    S_LEN_LO: begin
                        len_lo <= rx_data;
                        state  <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        len_q <= CW'(len_in);
                        cnt   <= '0;
                        chk   <= '0;
                        if (len_in > MAX_LEN) begin
                            err_frame <= 1'b1;
                            state     <= S_IDLE;
                        end else if (len_in == 16'd0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= cnt[ADDR_W-1:0];
                        mem_wdata <= rx_data;
                        chk       <= chk ^ rx_data;
                        cnt       <= cnt_nx;
                        if (cnt_nx == len_q) state <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (rx_data == chk) begin
                            frame_done <= 1'b1;
                            frame_cmd  <= cmd_q;
                        end else begin
                            err_chk <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (expire) begin
                err_timeout <= 1'b1;
                state       <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench for uart_frame_loader; frame outcomes derived from framing rules.
`timescale 1ns/1ps
module tb_uart_frame_loader;
    localparam logic [15:0] MAX_LEN = 16'd8192;
`ifdef LOADER_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 1_000_000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ready = 1'b0;
    logic        inf_busy = 1'b0;
    logic        busy, mem_we, mem_sel, frame_done, err_chk, err_frame, err_timeout;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, frame_cmd;

    int vectors = 0;
    int miscompares = 0;
    int n_done, n_chk, n_frame, n_to;
    logic [24:0] wq[$];
    logic [7:0]  pay[$];
    logic [7:0]  exp_cmd = 8'h00;

    uart_frame_loader #(.ADDR_W(16), .MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hAA), .TIMEOUT_CLKS(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ready(rx_ready), .inf_busy(inf_busy),
        .busy(busy), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .frame_done(frame_done), .frame_cmd(frame_cmd), .err_chk(err_chk), .err_frame(err_frame),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Observe writes and pulses mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) wq.push_back({mem_sel, mem_addr, mem_wdata});
            n_done  += int'(frame_done);
            n_chk   += int'(err_chk);
            n_frame += int'(err_frame);
            n_to    += int'(err_timeout);
            if (frame_done | err_chk | err_frame | err_timeout) begin
                vectors++;
                if (int'(frame_done) + int'(err_chk) + int'(err_frame) + int'(err_timeout) > 1) begin
                    miscompares++;
                    $display("FAIL pulse_exclusive: done=%b chk=%b frame=%b to=%b, required at most one",
                             frame_done, err_chk, err_frame, err_timeout);
                end
            end
        end
    end

    task automatic clear_obs();
        wq.delete();
        n_done = 0; n_chk = 0; n_frame = 0; n_to = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        if (gap > 0) idle(gap);
        rx_data = b;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic check_counts(input string tag, input int ed, input int ec, input int ef, input int nw);
        vectors += 4;
        if (n_done !== ed) begin miscompares++; $display("FAIL %s frame_done count: got %0d, want %0d", tag, n_done, ed); end
        if (n_chk !== ec) begin miscompares++; $display("FAIL %s err_chk count: got %0d, want %0d", tag, n_chk, ec); end
        if (n_frame !== ef) begin miscompares++; $display("FAIL %s err_frame count: got %0d, want %0d", tag, n_frame, ef); end
        if (wq.size() !== nw) begin miscompares++; $display("FAIL %s write count: got %0d, want %0d", tag, wq.size(), nw); end
    endtask

    // busy_mode: 0 idle, 1 inf_busy during CMD, 2 inf_busy raised after CMD.
    task automatic run_frame(input string tag, input logic [7:0] cmd, input int len,
                             input logic [7:0] chk_xor, input int busy_mode, input bit noise, input int max_gap);
        logic [7:0] x;
        bit ok_cmd, ok_len, good;
        logic [15:0] len16;
        clear_obs();
        len16 = 16'(len);
        ok_cmd = (cmd == 8'h02) || (cmd == 8'h01 && busy_mode != 1);
        ok_len = (len <= int'(MAX_LEN));
        good = ok_cmd && ok_len;
        if (ok_len) while (pay.size() < len) pay.push_back(8'($urandom));
        inf_busy = (busy_mode == 1);
        if (noise) begin send(8'h13, 0); send(8'h37, $urandom_range(0, max_gap)); end
        send(8'hAA, $urandom_range(0, max_gap));
        send(cmd, $urandom_range(0, max_gap));
        if (busy_mode == 2) inf_busy = 1'b1;
        if (ok_cmd) begin
            send(len16[7:0], $urandom_range(0, max_gap));
            send(len16[15:8], $urandom_range(0, max_gap));
            if (ok_len) begin
                x = 8'h00;
                foreach (pay[i]) begin send(pay[i], $urandom_range(0, max_gap)); x ^= pay[i]; end
                send(x ^ chk_xor, $urandom_range(0, max_gap));
            end
        end
        idle(2);
        inf_busy = 1'b0;
        check_counts(tag, (good && chk_xor == 0) ? 1 : 0, (good && chk_xor != 0) ? 1 : 0,
                     good ? 0 : 1, good ? len : 0);
        if (good && wq.size() == len) begin
            foreach (pay[i]) begin
                vectors++;
                if (wq[i] !== {cmd == 8'h02, 16'(i), pay[i]}) begin
                    miscompares++;
                    $display("FAIL %s write[%0d]: got %h, want %h", tag, i, wq[i], {cmd == 8'h02, 16'(i), pay[i]});
                end
            end
        end
        if (good && chk_xor == 0) exp_cmd = cmd;
        vectors += 3;
        if (frame_cmd !== exp_cmd) begin miscompares++; $display("FAIL %s frame_cmd: got %h, want %h", tag, frame_cmd, exp_cmd); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL %s busy after frame: got %b, want 0", tag, busy); end
        if (n_to !== 0) begin miscompares++; $display("FAIL %s err_timeout count: got %0d, want 0", tag, n_to); end
        pay.delete();
    endtask

    task automatic check_all_zero(input string tag);
        vectors++;
        if ({busy, mem_we, mem_sel, mem_addr, mem_wdata, frame_done, frame_cmd, err_chk, err_frame, err_timeout} !== '0) begin
            miscompares++;
            $display("FAIL %s outputs: busy=%b we=%b sel=%b addr=%h wdata=%h done=%b cmd=%h chk=%b frm=%b to=%b, want all 0",
                     tag, busy, mem_we, mem_sel, mem_addr, mem_wdata, frame_done, frame_cmd, err_chk, err_frame, err_timeout);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(1);
        check_all_zero("after_reset");
    endtask

    task automatic test_basic();
        pay = '{8'h10, 8'h20, 8'h30};
        run_frame("image3", 8'h01, 3, 8'h00, 0, 0, 0);
    endtask

    task automatic test_bad_chk();
        pay = '{8'h55, 8'hAA};
        run_frame("bad_chk", 8'h02, 2, 8'hFF, 0, 0, 0);
    endtask

    task automatic test_frame_errs();
        run_frame("img_busy", 8'h01, 4, 8'h00, 1, 0, 0);
        run_frame("bad_cmd", 8'h07, 0, 8'h00, 0, 0, 0);
        run_frame("len_big", 8'h02, int'(MAX_LEN) + 1, 8'h00, 0, 0, 0);
        run_frame("busy_mid", 8'h01, 5, 8'h00, 2, 0, 1);
    endtask

    task automatic test_zero_len_noise();
        run_frame("zero_len", 8'h02, 0, 8'h00, 0, 1, 0);
        pay = '{8'hAA, 8'hAA, 8'h01};
        run_frame("sync_in_data", 8'h01, 3, 8'h00, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] b, x;
        clear_obs();
        send(8'hAA, 0); send(8'h02, 0); send(8'h04, 0); send(8'h00, 0);
        x = 8'h00;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            x ^= b;
            send(b, 0);
            vectors++;
            if ({mem_we, mem_sel, mem_addr, mem_wdata} !== {2'b11, 16'(i), b}) begin
                miscompares++;
                $display("FAIL b2b write %0d: we=%b sel=%b addr=%h data=%h, want 1 1 %h %h",
                         i, mem_we, mem_sel, mem_addr, mem_wdata, 16'(i), b);
            end
        end
        send(x, 0);
        vectors++;
        if (frame_done !== 1'b1) begin miscompares++; $display("FAIL b2b done latency: got %b, want 1", frame_done); end
        idle(2);
        check_counts("b2b", 1, 0, 0, 4);
        exp_cmd = 8'h02;
    endtask

    task automatic test_max_len();
        run_frame("max_len", 8'h02, int'(MAX_LEN), 8'h00, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        send(8'hAA, 0); send(8'h01, 0); send(8'h05, 0); send(8'h00, 0);
        send(8'h11, 0); send(8'h22, 0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cmd = 8'h00;
        check_all_zero("reset_mid");
        idle(2);
        rst_n = 1'b1;
        idle(1);
        run_frame("after_reset_mid", 8'h01, 6, 8'h00, 0, 0, 0);
    endtask

    task automatic test_random();
        int r, len, bm;
        logic [7:0] cmd, cx;
        for (int f = 0; f < 30; f++) begin
            r = $urandom_range(0, 9);
            cmd = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : 8'($urandom_range(3, 255));
            len = ($urandom_range(0, 14) == 0) ? int'(MAX_LEN) + $urandom_range(1, 3) : $urandom_range(0, 24);
            cx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            bm = $urandom_range(0, 2);
            if (len > 0 && len <= int'(MAX_LEN) && $urandom_range(0, 3) == 0) pay.push_back(8'hAA);
            run_frame("random", cmd, len, cx, bm, 1'($urandom_range(0, 1)), 2);
        end
    endtask

`ifdef LOADER_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] b0, b1;
        clear_obs();
        send(8'hAA, 0); send(8'h02, 0); send(8'h03, 0); send(8'h00, 0);
        idle(TO);
        vectors += 2;
        if (err_timeout !== 1'b1) begin miscompares++; $display("FAIL timeout pulse: got %b, want 1", err_timeout); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL timeout busy: got %b, want 0", busy); end
        idle(2);
        check_counts("timeout", 0, 0, 0, 0);
        vectors++;
        if (n_to !== 1) begin miscompares++; $display("FAIL timeout count: got %0d, want 1", n_to); end
        clear_obs();
        b0 = 8'($urandom); b1 = 8'($urandom);
        send(8'hAA, 0); send(8'h02, 0); send(8'h02, 0); send(8'h00, 0);
        send(b0, TO - 1); send(b1, TO - 1); send(b0 ^ b1, TO - 1);
        idle(2);
        check_counts("limit_byte", 1, 0, 0, 2);
        vectors++;
        if (n_to !== 0) begin miscompares++; $display("FAIL limit_byte timeout count: got %0d, want 0", n_to); end
        exp_cmd = 8'h02;
    endtask
`else
    task automatic test_stall();
        logic [7:0] b;
        clear_obs();
        b = 8'($urandom);
        send(8'hAA, 0); send(8'h01, 0); send(8'h01, 0); send(8'h00, 0);
        idle(300);
        vectors += 2;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL stall busy: got %b, want 1", busy); end
        if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL stall err_timeout: got %b, want 0", err_timeout); end
        send(b, 0);
        send(b, 300);
        idle(2);
        check_counts("stall", 1, 0, 0, 1);
        vectors++;
        if (n_to !== 0) begin miscompares++; $display("FAIL stall timeout count: got %0d, want 0", n_to); end
        exp_cmd = 8'h01;
    endtask
`endif

    initial begin
        clear_obs();
        test_reset();
        test_basic();
        test_bad_chk();
        test_frame_errs();
        test_zero_len_noise();
        test_back_to_back();
        test_max_len();
        test_reset_mid();
        test_random();
`ifdef LOADER_TIMEOUT_EN
        test_timeout();
`else
        test_stall();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
